// File: rtl/sr_ff_monitor_if.sv
// Stimulus and result bundle between an SR flip-flop stimulus source and sr_ff_monitor.
// Coverage counters appear only when SR_FF_MONITOR_COVERAGE_EN is defined.
interface sr_ff_monitor_if #(
   parameter int CNT_W = 8
);
   logic             en;
   logic             s;
   logic             r;
   logic             q;
   logic             qbar;
   logic             exp_q;
   logic             valid;
   logic             err;
   logic [CNT_W-1:0] err_count;
   logic             forbid;
   logic [CNT_W-1:0] forbid_count;
   logic             halted;
`ifdef SR_FF_MONITOR_COVERAGE_EN
   logic [CNT_W-1:0] set_count;
   logic [CNT_W-1:0] clr_count;
   logic [CNT_W-1:0] hold_count;
`endif

   modport master (
      output en, s, r, q, qbar,
      input  exp_q, valid, err, err_count, forbid, forbid_count, halted
`ifdef SR_FF_MONITOR_COVERAGE_EN
      , input set_count, clr_count, hold_count
`endif
   );

   modport slave (
      input  en, s, r, q, qbar,
      output exp_q, valid, err, err_count, forbid, forbid_count, halted
`ifdef SR_FF_MONITOR_COVERAGE_EN
      , output set_count, clr_count, hold_count
`endif
   );
endinterface

// File: rtl/sr_ff_monitor.sv
// Cycle-accurate response checker for a clocked SR flip-flop: one-step prediction, error/forbidden
// pulses and saturating counters. Optional input coverage counters under SR_FF_MONITOR_COVERAGE_EN.
module sr_ff_monitor #(
   parameter int CNT_W       = 8,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   sr_ff_monitor_if.slave mon
);
   localparam logic [1:0] UNSYNC = 2'd0;
   localparam logic [1:0] TRACK  = 2'd1;
   localparam logic [1:0] HALT   = 2'd2;

   logic [1:0]       state;
   logic             exp_q;
   logic             valid;
   logic             err;
   logic             forbid;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] forbid_count;
   logic             mism;
   logic             forb;
`ifdef SR_FF_MONITOR_COVERAGE_EN
   logic [CNT_W-1:0] set_count;
   logic [CNT_W-1:0] clr_count;
   logic [CNT_W-1:0] hold_count;
`endif

   function automatic logic nxt(input logic q, input logic s, input logic r);
      case ({s, r})
         2'b10:   return 1'b1;
         2'b01:   return 1'b0;
         default: return q;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // An unresolved output (q==qbar) while tracking counts as a mismatch too.
   assign mism = (mon.q != exp_q) || (mon.q == mon.qbar);
   assign forb = mon.s & mon.r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= UNSYNC;
         exp_q        <= 1'b0;
         valid        <= 1'b0;
         err          <= 1'b0;
         forbid       <= 1'b0;
         err_count    <= '0;
         forbid_count <= '0;
      end else begin
         err    <= 1'b0;
         forbid <= 1'b0;
         if (mon.en) begin
            case (state)
               UNSYNC: begin
                  if (forb) begin
                     forbid       <= 1'b1;
                     forbid_count <= sat_inc(forbid_count);
                  end else if (mon.q != mon.qbar) begin
                     exp_q <= nxt(mon.q, mon.s, mon.r);
                     valid <= 1'b1;
                     state <= TRACK;
                  end
               end
               TRACK: begin
                  if (mism) begin
                     err       <= 1'b1;
                     err_count <= sat_inc(err_count);
                  end
                  if (forb) begin
                     forbid       <= 1'b1;
                     forbid_count <= sat_inc(forbid_count);
                     valid        <= 1'b0;
                     state        <= UNSYNC;
                  end else begin
                     exp_q <= nxt(mon.q, mon.s, mon.r);
                  end
                  // Halting wins over the resync transition on the same edge.
                  if (mism && STOP_ON_ERR)
                     state <= HALT;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef SR_FF_MONITOR_COVERAGE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         set_count  <= '0;
         clr_count  <= '0;
         hold_count <= '0;
      end else if (mon.en && state != HALT) begin
         case ({mon.s, mon.r})
            2'b10:   set_count  <= sat_inc(set_count);
            2'b01:   clr_count  <= sat_inc(clr_count);
            2'b00:   hold_count <= sat_inc(hold_count);
            default: ;
         endcase
      end
   end

   assign mon.set_count  = set_count;
   assign mon.clr_count  = clr_count;
   assign mon.hold_count = hold_count;
`endif

   assign mon.exp_q        = exp_q;
   assign mon.valid        = valid;
   assign mon.err          = err;
   assign mon.err_count    = err_count;
   assign mon.forbid       = forbid;
   assign mon.forbid_count = forbid_count;
   assign mon.halted       = (state == HALT);
endmodule

// File: tb/tb_sr_ff_monitor.sv
// Directed bench for sr_ff_monitor: three instances (default, halt-on-error, 2-bit counters)
// share one stimulus stream; flip-flop outputs are driven as hand-computed vectors.
module tb_sr_ff_monitor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b1, s = 1'b0, r = 1'b0, q = 1'b0, qbar = 1'b1;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   sr_ff_monitor_if #(.CNT_W(8)) bus0 ();
   sr_ff_monitor_if #(.CNT_W(8)) bus1 ();
   sr_ff_monitor_if #(.CNT_W(2)) bus2 ();

   assign bus0.en = en; assign bus0.s = s; assign bus0.r = r; assign bus0.q = q; assign bus0.qbar = qbar;
   assign bus1.en = en; assign bus1.s = s; assign bus1.r = r; assign bus1.q = q; assign bus1.qbar = qbar;
   assign bus2.en = en; assign bus2.s = s; assign bus2.r = r; assign bus2.q = q; assign bus2.qbar = qbar;

   sr_ff_monitor #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut0 (.clk(clk), .rst(rst), .mon(bus0.slave));
   sr_ff_monitor #(.CNT_W(8), .STOP_ON_ERR(1'b1)) dut1 (.clk(clk), .rst(rst), .mon(bus1.slave));
   sr_ff_monitor #(.CNT_W(2), .STOP_ON_ERR(1'b0)) dut2 (.clk(clk), .rst(rst), .mon(bus2.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic drive(input logic sv, input logic rv, input logic qv, input logic qbv);
      s = sv; r = rv; q = qv; qbar = qbv;
   endtask

   initial begin
      // Reset held for two cycles with random inputs
      rst = 1'b1;
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      chk("rst_valid_c1", 32'(bus0.valid), 0);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      chk("rst_valid_c2", 32'(bus0.valid), 0);
      chk("rst_exp_q", 32'(bus0.exp_q), 0);
      chk("rst_err", 32'(bus0.err), 0);
      chk("rst_forbid", 32'(bus0.forbid), 0);
      chk("rst_err_count", 32'(bus0.err_count), 0);
      chk("rst_forbid_count", 32'(bus0.forbid_count), 0);
      chk("rst_halted", 32'(bus1.halted), 0);

      // Correct flip-flop from q=0: s r = 10, 00, 01, 00
      rst = 1'b0;
      drive(1, 0, 0, 1); tick();
      chk("good_exp1", 32'(bus0.exp_q), 1);
      chk("good_valid", 32'(bus0.valid), 1);
      drive(0, 0, 1, 0); tick();
      chk("good_exp2", 32'(bus0.exp_q), 1);
      drive(0, 1, 1, 0); tick();
      chk("good_exp3", 32'(bus0.exp_q), 0);
      drive(0, 0, 0, 1); tick();
      chk("good_exp4", 32'(bus0.exp_q), 0);
      chk("good_err_count", 32'(bus0.err_count), 0);
      chk("good_valid_end", 32'(bus0.valid), 1);

      // Fault: flip-flop should reach q=1 but stays 0 for one cycle
      drive(1, 0, 0, 1); tick();
      chk("pre_fault_exp", 32'(bus0.exp_q), 1);
      drive(0, 0, 0, 1); tick();
      chk("fault_err", 32'(bus0.err), 1);
      chk("fault_err_count", 32'(bus0.err_count), 1);
      drive(0, 0, 0, 1); tick();
      chk("fault_err_gone", 32'(bus0.err), 0);
      drive(1, 0, 0, 1); tick();
      drive(0, 0, 1, 0); tick();
      chk("resume_err", 32'(bus0.err), 0);
      chk("resume_err_count", 32'(bus0.err_count), 1);
      chk("resume_exp", 32'(bus0.exp_q), 1);

      // Forbidden input, flip-flop then unresolved, then resolved again
      drive(1, 1, 1, 0); tick();
      chk("forb_pulse", 32'(bus0.forbid), 1);
      chk("forb_count", 32'(bus0.forbid_count), 1);
      chk("forb_valid", 32'(bus0.valid), 0);
      chk("forb_no_err", 32'(bus0.err), 0);
      drive(0, 0, 1, 1); tick();
      chk("unres_forbid", 32'(bus0.forbid), 0);
      chk("unres_valid", 32'(bus0.valid), 0);
      chk("unres_err", 32'(bus0.err), 0);
      drive(0, 0, 0, 1); tick();
      chk("resync_valid", 32'(bus0.valid), 1);
      chk("resync_exp", 32'(bus0.exp_q), 0);
      chk("resync_err_count", 32'(bus0.err_count), 1);

      // Disabled cycle with a would-be mismatch is invisible
      en = 1'b0;
      drive(1, 0, 1, 0); tick();
      chk("en0_exp", 32'(bus0.exp_q), 0);
      chk("en0_err", 32'(bus0.err), 0);
      chk("en0_err_count", 32'(bus0.err_count), 1);
      en = 1'b1;
      drive(0, 0, 0, 1); tick();
      chk("en1_err", 32'(bus0.err), 0);
      chk("en1_err_count", 32'(bus0.err_count), 1);

      // Halt on first error, further mismatches ignored
      rst = 1'b1; tick();
      rst = 1'b0;
      drive(0, 0, 0, 1); tick();
      chk("halt_sync_valid", 32'(bus1.valid), 1);
      drive(0, 0, 1, 0); tick();
      chk("halt_err", 32'(bus1.err), 1);
      chk("halt_halted", 32'(bus1.halted), 1);
      chk("halt_err_count", 32'(bus1.err_count), 1);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 1'(i % 2 == 0 ? 0 : 1), 1'(i % 2 == 0 ? 1 : 0));
         tick();
      end
      chk("halt_still", 32'(bus1.halted), 1);
      chk("halt_count_frozen", 32'(bus1.err_count), 1);
      chk("halt_no_err", 32'(bus1.err), 0);
      rst = 1'b1; tick();
      chk("halt_rst_halted", 32'(bus1.halted), 0);
      chk("halt_rst_count", 32'(bus1.err_count), 0);
      chk("halt_rst_valid", 32'(bus1.valid), 0);
      chk("halt_rst_exp", 32'(bus1.exp_q), 0);

      // Saturation with 2-bit counters
      rst = 1'b0;
      drive(0, 0, 0, 1); tick();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 1'(i % 2 == 0 ? 1 : 0), 1'(i % 2 == 0 ? 0 : 1));
         tick();
      end
      chk("sat_err_count", 32'(bus2.err_count), 3);
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 1, 0);
         tick();
      end
      chk("sat_forbid_count", 32'(bus2.forbid_count), 3);
      chk("sat_forbid_pulse", 32'(bus2.forbid), 1);
      chk("sat_err_count_held", 32'(bus2.err_count), 3);
      drive(0, 0, 1, 0); tick();
      chk("sat_forbid_end", 32'(bus2.forbid), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/sr_ff_monitor.md
# sr_ff_monitor

Cycle-accurate response checker for the clocked SR flip-flop. It samples the same `s`/`r` stimulus the flip-flop sees, along with the flip-flop's `q`/`qbar`. Each cycle it predicts the next state, flags mismatches and forbidden `s=r=1` inputs, and keeps saturating event counters. It sits beside the flip-flop in benches and in self-test wrappers as the receiving end of the stimulus stream.

## Interface
- `CNT_W`, default 8: width of every counter output.
- `STOP_ON_ERR`, default 0: when 1, the first mismatch freezes the monitor until reset.
- `clk`, in, 1: rising-edge clock, shared with the flip-flop.
- `rst`, in, 1: reset, synchronous and active-high.
- `en`, in, 1: sample enable. When 0, all state is held and no pulses are produced.
- `s`, in, 1: set input, the same net that drives the flip-flop.
- `r`, in, 1: reset input, the same net that drives the flip-flop.
- `q`, in, 1: flip-flop output.
- `qbar`, in, 1: flip-flop complementary output.
- `exp_q`, out, 1: predicted `q` for the next sample.
- `valid`, out, 1: `exp_q` is meaningful.
- `err`, out, 1: one-cycle registered pulse on a mismatch.
- `err_count`, out, `CNT_W`: number of mismatches, saturating.
- `forbid`, out, 1: one-cycle registered pulse when `s=r=1` is sampled.
- `forbid_count`, out, `CNT_W`: number of forbidden inputs, saturating.
- `halted`, out, 1: the monitor is in the HALT state.

## Operation
- The prediction function is `nxt(q,s,r)`:
  - `10` gives 1.
  - `01` gives 0.
  - `00` gives `q`.
  - `11` is forbidden; there is no prediction.
- The prediction is a one-step model. `exp_q` is always computed from the observed `q`, so a single fault produces exactly one `err`.
- States:
  - UNSYNC is the reset state.
  - TRACK is entered once a prediction is held.
  - HALT is entered only when `STOP_ON_ERR=1`.
- UNSYNC, on an edge with `en=1`:
  - If `s&r`: pulse `forbid`, increment `forbid_count`, stay in UNSYNC.
  - Else if `q==qbar`: stay in UNSYNC with no error, because the flip-flop is not yet resolved.
  - Otherwise: set `exp_q<=nxt(q,s,r)` and `valid<=1`, then go to TRACK.
- TRACK, on an edge with `en=1`:
  - Mismatch check: if `q!=exp_q` or `q==qbar`, pulse `err` and increment `err_count`.
  - If `s&r`: pulse `forbid`, increment `forbid_count`, set `valid<=0`, go to UNSYNC.
  - Otherwise: set `exp_q<=nxt(q,s,r)`.
  - An error with `STOP_ON_ERR=1` goes to HALT. This takes priority over the UNSYNC transition.
  - A mismatch and a forbidden input on the same edge produce both pulses and both increments.
- HALT:
  - `halted=1`.
  - All counters, `exp_q` and `valid` are frozen.
  - No pulses are produced.
  - The only exit is `rst`.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values: state UNSYNC, and `exp_q`, `valid`, `err`, `forbid`, `halted` and both counters all 0.
- `rst` overrides `en` and any state, including HALT, on the same edge.
- The flip-flop updates `q` at edge k from `s`/`r` sampled at edge k. The monitor predicts at edge k and compares at edge k+1, giving one cycle of check latency.
- Pulse and counter timing:
  - `err` and `forbid` are high for exactly the cycle after the triggering edge.
  - Counters update on the same edge that raises the pulse.
- `valid` rises the cycle after the first resolved sample in UNSYNC. It falls the cycle after a forbidden sample.
- `en=0` cycles are invisible: no comparison is made and the pending `exp_q` carries over to the next enabled edge.

## Configuration
- Macro `SR_FF_MONITOR_COVERAGE_EN`.
- When defined, three extra `CNT_W` outputs `set_count`, `clr_count` and `hold_count` count the `10`, `01` and `00` inputs sampled with `en=1` outside HALT. They are saturating and reset to 0.
- When undefined, those ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Reset: hold `rst=1` for 2 cycles with random `s`/`r`/`q`. All outputs are 0 and `valid` stays 0 while `rst` is held.
- Correct flip-flop, starting from `q=0`:
  - Stimulus: `s r` = `10`, `00`, `01`, `00`, one cycle each.
  - `exp_q` sequence is 1, 1, 0, 0.
  - `err_count=0` and `valid=1` from the cycle after the first edge.
- Injected fault, `STOP_ON_ERR=0`: force `q=0` for one cycle while `exp_q=1`. Exactly one `err` pulse, `err_count=1`, and tracking resumes with no further errors.
- Forbidden input:
  - Drive `s=r=1` for one cycle, with the flip-flop giving `q=qbar`.
  - `forbid` pulses once and `forbid_count=1`.
  - `valid=0` on the next cycle with no `err`.
  - The monitor resyncs (`valid=1`) one cycle after `q!=qbar` returns.
- Halt, `STOP_ON_ERR=1`:
  - Produce one mismatch, then 5 more.
  - `halted=1` and `err_count` stays at 1.
  - `rst` for 1 cycle clears everything to 0.
- Saturation, `CNT_W=2`: 5 mismatches give `err_count=3`. Then 4 forbidden inputs give `forbid_count=3`.
